// File: rtl/cpu_run_pkg.sv
// Shared state encoding and halt-code constants for the CPU run-control block.
package cpu_run_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RESET     = 3'd1,
    ST_RUN       = 3'd2,
    ST_STEP_WAIT = 3'd3,
    ST_DONE      = 3'd4
  } run_state_e;

  localparam logic [2:0] HALT_NONE    = 3'd0;
  localparam logic [2:0] HALT_ECALL   = 3'd1;
  localparam logic [2:0] HALT_LOOP    = 3'd2;
  localparam logic [2:0] HALT_TIMEOUT = 3'd3;
  localparam logic [2:0] HALT_BREAK   = 3'd4;

  localparam logic [31:0] HALT_INSTR_DEFAULT = 32'h0000_0073;

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Host-side bundle of the run controller; bp_valid/bp_addr exist only when
// CPU_RUN_CTRL_BREAK_EN is defined.
interface cpu_run_ctrl_if #(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned CYC_W = 32
) ();

  logic             start;
  logic             step_mode;
  logic             step_req;
  logic [PC_W-1:0]  pc_in;
  logic [31:0]      inst_in;
  logic             cpu_rst;
  logic             cpu_ce;
  logic             busy;
  logic             done;
  logic [2:0]       halt_code;
  logic [CYC_W-1:0] cycle_cnt;
`ifdef CPU_RUN_CTRL_BREAK_EN
  logic             bp_valid;
  logic [PC_W-1:0]  bp_addr;

  modport master (
    output start, step_mode, step_req, pc_in, inst_in, bp_valid, bp_addr,
    input  cpu_rst, cpu_ce, busy, done, halt_code, cycle_cnt
  );

  modport slave (
    input  start, step_mode, step_req, pc_in, inst_in, bp_valid, bp_addr,
    output cpu_rst, cpu_ce, busy, done, halt_code, cycle_cnt
  );
`else
  modport master (
    output start, step_mode, step_req, pc_in, inst_in,
    input  cpu_rst, cpu_ce, busy, done, halt_code, cycle_cnt
  );

  modport slave (
    input  start, step_mode, step_req, pc_in, inst_in,
    output cpu_rst, cpu_ce, busy, done, halt_code, cycle_cnt
  );
`endif

endinterface

// File: rtl/cpu_halt_detect.sv
// Program-end detection on enabled cycles: ecall, optional breakpoint
// (CPU_RUN_CTRL_BREAK_EN) and PC self-loop, in that priority order.
module cpu_halt_detect
  import cpu_run_pkg::*;
#(
  parameter int unsigned PC_W        = 32,
  parameter int unsigned LOOP_REPEAT = 3,
  parameter logic [31:0] HALT_INSTR  = HALT_INSTR_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr_i,
  input  logic            en_i,
  input  logic [PC_W-1:0] pc_i,
  input  logic [31:0]     inst_i,
`ifdef CPU_RUN_CTRL_BREAK_EN
  input  logic            bp_valid_i,
  input  logic [PC_W-1:0] bp_addr_i,
`endif
  output logic [2:0]      code_o
);

  localparam int unsigned REP_W = $clog2(LOOP_REPEAT);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(LOOP_REPEAT - 1);

  logic [PC_W-1:0]  prev_pc_q;
  logic             prev_vld_q;
  logic [REP_W-1:0] rep_q;
  logic [REP_W-1:0] rep_d;
  logic             same_pc;
  logic             loop_hit;

  assign same_pc  = prev_vld_q && (pc_i == prev_pc_q);
  assign rep_d    = same_pc ? rep_q + REP_W'(1) : '0;
  assign loop_hit = same_pc && (rep_d == REP_LAST);

  always_comb begin
    code_o = HALT_NONE;
    if (en_i) begin
      if (inst_i == HALT_INSTR) code_o = HALT_ECALL;
`ifdef CPU_RUN_CTRL_BREAK_EN
      else if (bp_valid_i && (pc_i == bp_addr_i)) code_o = HALT_BREAK;
`endif
      else if (loop_hit) code_o = HALT_LOOP;
    end
  end

  // The previous PC is only meaningful once an enabled cycle of this run has been seen.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      prev_vld_q <= 1'b0;
      rep_q      <= '0;
    end else if (en_i) begin
      prev_vld_q <= 1'b1;
      rep_q      <= rep_d;
    end
  end

  always_ff @(posedge clk) begin
    if (en_i) prev_pc_q <= pc_i;
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run control for the single-cycle core: reset sequencing, free-run/single-step
// clock-enable, cycle counting and halt detection. Breakpoints: CPU_RUN_CTRL_BREAK_EN.
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int unsigned RST_CYCLES  = 4,
  parameter int unsigned PC_W        = 32,
  parameter int unsigned CYC_W       = 32,
  parameter int unsigned TIMEOUT     = 100000,
  parameter int unsigned LOOP_REPEAT = 3,
  parameter logic [31:0] HALT_INSTR  = HALT_INSTR_DEFAULT
) (
  input logic           clk,
  input logic           rst,
  cpu_run_ctrl_if.slave bus
);

  localparam int unsigned RCNT_W = $clog2(RST_CYCLES + 1);
  localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(RST_CYCLES - 1);
  localparam logic [CYC_W-1:0]  TIMEOUT_C = CYC_W'(TIMEOUT);

  run_state_e        state_q;
  logic [RCNT_W-1:0] rcnt_q;
  logic              mode_q;
  logic              cpu_rst_q;
  logic              cpu_ce_q;
  logic              busy_q;
  logic              done_q;
  logic [2:0]        halt_q;
  logic [CYC_W-1:0]  cnt_q;

  logic [2:0]        det_code;
  logic [2:0]        halt_req;
  logic              bp_mask;
  logic              ce_eff;
  logic [CYC_W-1:0]  cnt_inc;

  cpu_halt_detect #(
    .PC_W        (PC_W),
    .LOOP_REPEAT (LOOP_REPEAT),
    .HALT_INSTR  (HALT_INSTR)
  ) u_halt (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (state_q == ST_RESET),
    .en_i       (cpu_ce_q),
    .pc_i       (bus.pc_in),
    .inst_i     (bus.inst_in),
`ifdef CPU_RUN_CTRL_BREAK_EN
    .bp_valid_i (bus.bp_valid),
    .bp_addr_i  (bus.bp_addr),
`endif
    .code_o     (det_code)
  );

  // A breakpoint hit suppresses the commit strobe in the same cycle.
  assign bp_mask = (det_code == HALT_BREAK);
  assign ce_eff  = cpu_ce_q & ~bp_mask;
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CYC_W'(1);

  always_comb begin
    halt_req = det_code;
    if ((halt_req == HALT_NONE) && ce_eff && (cnt_inc == TIMEOUT_C)) halt_req = HALT_TIMEOUT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rcnt_q    <= '0;
      mode_q    <= 1'b0;
      cpu_rst_q <= 1'b1;
      cpu_ce_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      halt_q    <= HALT_NONE;
      cnt_q     <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state_q   <= ST_RESET;
            rcnt_q    <= '0;
            cpu_rst_q <= 1'b1;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            halt_q    <= HALT_NONE;
            cnt_q     <= '0;
          end
        end
        ST_RESET: begin
          rcnt_q <= rcnt_q + RCNT_W'(1);
          if (rcnt_q == RCNT_LAST) begin
            mode_q    <= bus.step_mode;
            cpu_rst_q <= 1'b0;
            cpu_ce_q  <= ~bus.step_mode;
            state_q   <= bus.step_mode ? ST_STEP_WAIT : ST_RUN;
          end
        end
        ST_RUN, ST_STEP_WAIT: begin
          if (ce_eff) cnt_q <= cnt_inc;
          if (halt_req != HALT_NONE) begin
            state_q  <= ST_DONE;
            halt_q   <= halt_req;
            cpu_ce_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end else begin
            cpu_ce_q <= mode_q ? bus.step_req : 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.cpu_rst   = cpu_rst_q;
  assign bus.cpu_ce    = ce_eff;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.halt_code = halt_q;
  assign bus.cycle_cnt = cnt_q;

endmodule
